// File: rtl/hamming_nibble_packer.sv
`default_nettype none
// ============================================================================
//  Module      : hamming_nibble_packer
//  Description : Packs corrected Hamming (7,4) nibbles into bytes, high nibble
//                first, and queues them in a show-ahead FIFO. Keeps a
//                saturating corrected-error counter and a sticky overflow flag.
//  Ports       : clk, rst_n            clock, async active-low reset
//                i_ena                 global enable (0 freezes all state)
//                i_nib_valid/data/syndrome   decoder nibble interface
//                i_flush               emit pending half-byte padded with 4'h0
//                i_clear_stats         clear err_count and overflow
//                i_byte_ready          downstream ready
//                o_byte_valid/data/err/partial   FIFO head
//                o_fifo_count          FIFO occupancy (0..DEPTH)
//                o_err_count           accepted nibbles with nonzero syndrome
//                o_overflow            sticky byte-dropped flag
//  Revision    : 1.0  initial release
// ============================================================================
module hamming_nibble_packer #(
    parameter int DEPTH     = 4,
    parameter int CNT_W     = 8,
    parameter int EDGE_MODE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_ena,
    input  logic                     i_nib_valid,
    input  logic [3:0]               i_nib_data,
    input  logic [2:0]               i_nib_syndrome,
    input  logic                     i_flush,
    input  logic                     i_clear_stats,
    input  logic                     i_byte_ready,
    output logic                     o_byte_valid,
    output logic [7:0]               o_byte_data,
    output logic                     o_byte_err,
    output logic                     o_byte_partial,
    output logic [$clog2(DEPTH):0]   o_fifo_count,
    output logic [CNT_W-1:0]         o_err_count,
    output logic                     o_overflow
);

    localparam int c_PTR_W = $clog2(DEPTH);

    typedef enum logic [0:0] {
        S_EMPTY = 1'b0,
        S_HALF  = 1'b1
    } state_t;

    state_t               r_state, w_state_nxt;
    logic                 r_nv_q;
    logic [3:0]           r_hi;
    logic                 r_hi_err;
    logic [c_PTR_W-1:0]   r_wr_ptr, r_rd_ptr;
    logic [c_PTR_W:0]     r_count;
    logic [CNT_W-1:0]     r_err_count;
    logic                 r_overflow;
    logic [7:0]           r_mem_data [DEPTH];
    logic                 r_mem_err  [DEPTH];
    logic                 r_mem_part [DEPTH];

    logic                 w_accept, w_flush, w_syn_err;
    logic                 w_hi_load;
    logic                 w_push, w_push_err, w_push_part;
    logic [7:0]           w_push_data;
    logic                 w_pop, w_full, w_do_push, w_drop;

    // In edge mode only the 0->1 transition of nib_valid counts as a nibble.
    assign w_accept  = i_ena & i_nib_valid & ((EDGE_MODE != 0) ? ~r_nv_q : 1'b1);
    assign w_flush   = i_ena & i_flush;
    assign w_syn_err = (i_nib_syndrome != 3'd0);

    // Pending half-byte FSM: a nibble arriving with flush is handled first.
    always_comb begin
        w_state_nxt = r_state;
        w_hi_load   = 1'b0;
        w_push      = 1'b0;
        w_push_data = 8'h00;
        w_push_err  = 1'b0;
        w_push_part = 1'b0;
        case (r_state)
            S_EMPTY: begin
                if (w_accept && w_flush) begin
                    w_push      = 1'b1;
                    w_push_data = {i_nib_data, 4'h0};
                    w_push_err  = w_syn_err;
                    w_push_part = 1'b1;
                end else if (w_accept) begin
                    w_hi_load   = 1'b1;
                    w_state_nxt = S_HALF;
                end
            end
            S_HALF: begin
                if (w_accept) begin
                    w_push      = 1'b1;
                    w_push_data = {r_hi, i_nib_data};
                    w_push_err  = r_hi_err | w_syn_err;
                    w_state_nxt = S_EMPTY;
                end else if (w_flush) begin
                    w_push      = 1'b1;
                    w_push_data = {r_hi, 4'h0};
                    w_push_err  = r_hi_err;
                    w_push_part = 1'b1;
                    w_state_nxt = S_EMPTY;
                end
            end
            default: w_state_nxt = S_EMPTY;
        endcase
    end

    assign w_pop     = i_ena & o_byte_valid & i_byte_ready;
    assign w_full    = (r_count == DEPTH[c_PTR_W:0]);
    // A pop in the same cycle frees the slot the push needs.
    assign w_do_push = w_push & (~w_full | w_pop);
    assign w_drop    = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_EMPTY;
            r_nv_q      <= 1'b0;
            r_hi        <= 4'h0;
            r_hi_err    <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_err_count <= '0;
            r_overflow  <= 1'b0;
        end else if (i_ena) begin
            r_state <= w_state_nxt;
            r_nv_q  <= i_nib_valid;
            if (w_hi_load) begin
                r_hi     <= i_nib_data;
                r_hi_err <= w_syn_err;
            end
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (i_clear_stats) begin
                r_err_count <= '0;
                r_overflow  <= 1'b0;
            end else begin
                if (w_accept && w_syn_err && (r_err_count != {CNT_W{1'b1}}))
                    r_err_count <= r_err_count + 1'b1;
                if (w_drop)
                    r_overflow <= 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible while counted valid.
    always_ff @(posedge clk) begin
        if (i_ena && w_do_push) begin
            r_mem_data[r_wr_ptr] <= w_push_data;
            r_mem_err[r_wr_ptr]  <= w_push_err;
            r_mem_part[r_wr_ptr] <= w_push_part;
        end
    end

    assign o_byte_valid   = (r_count != '0);
    assign o_byte_data    = o_byte_valid ? r_mem_data[r_rd_ptr] : 8'h00;
    assign o_byte_err     = o_byte_valid & r_mem_err[r_rd_ptr];
    assign o_byte_partial = o_byte_valid & r_mem_part[r_rd_ptr];
    assign o_fifo_count   = r_count;
    assign o_err_count    = r_err_count;
    assign o_overflow     = r_overflow;

endmodule
`default_nettype wire
